data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares the data-side bus between two masters: the CPU load/store port (master 0) and a DMA/UART block-transfer engine (master 1).
- Arbitrates ownership, then routes the granted master's access to one of two slaves: DataMemory when addr[30]=0, Peripheral when addr[30]=1.
- Sits between the processor datapath (ALU_out/DataBusB/MemRead/MemWrite) and the memory/peripheral slaves.
- Produces a stall to freeze the CPU PC while the CPU is not granted.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BURST, 8, max consecutive accesses by one owner while the other master waits (1..255).
- SEL_BIT, 30, address bit selecting peripheral (1) vs data memory (0).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low; all state cleared on negedge reset.
- m0_req  in  1  CPU requests access this cycle.
- m0_rd, m0_wr  in  1 each  CPU read/write strobes.
- m0_addr  in  ADDR_W  CPU address.
- m0_wdata  in  DATA_W  CPU write data.
- m0_ack  out  1  CPU access performed this cycle.
- m0_rdata  out  DATA_W  CPU read data, valid when m0_ack.
- cpu_stall  out  1  =m0_req & ~m0_ack.
- m1_req, m1_rd, m1_wr, m1_addr, m1_wdata  in  as m0  DMA side.
- m1_ack  out  1  DMA handshake.
- m1_rdata  out  DATA_W  DMA handshake read data.
- mem_rd, mem_wr  out  1 each  DataMemory strobes.
- mem_addr  out  ADDR_W  DataMemory address.
- mem_wdata  out  DATA_W  DataMemory write data.
- mem_rdata  in  DATA_W  DataMemory combinational read data.
- per_rd, per_wr  out  1 each  Peripheral strobes.
- per_addr  out  ADDR_W  Peripheral address.
- per_wdata  out  DATA_W  Peripheral write data.
- per_rdata  in  DATA_W  Peripheral read data.
- owner  out  2  one-hot current owner, for debug.

Behaviour:
- Reset:
  - state=IDLE, last_gnt=1 so the CPU wins the first tie, burst_cnt=0.
  - All strobes, acks and owner are 0; rdata outputs are 0.
- FSM states: IDLE, OWN0, OWN1. The state register alone drives the slave buses; the muxes are combinational on state.
- IDLE:
  - m0_req only -> OWN0.
  - m1_req only -> OWN1.
  - both -> owner is ~last_gnt (round robin).
  - No slave strobes and no ack in IDLE: one-cycle arbitration latency from IDLE.
- OWNx:
  - Master x's rd/wr/addr/wdata are routed to the slave selected by addr[SEL_BIT]. The unselected slave sees rd=wr=0.
  - mx_ack = mx_req. mx_rdata = selected slave rdata. The other master's ack is 0.
  - Each acked access increments burst_cnt, saturating at MAX_BURST.
- Release:
  - In OWNx, if mx_req=0 -> if the other master requests go directly to its OWN state, else IDLE.
  - If burst_cnt==MAX_BURST-1 while acking and the other master requests -> switch owner after this access.
  - On any owner change: last_gnt := new owner, burst_cnt := 0.
- Back-to-back: a master holding req stays owner with zero-bubble single-cycle accesses.
- rd and wr both set: the write takes precedence; the slave rd strobe is still forwarded; ack is a single cycle.
- Asynchronous reset mid-access aborts immediately; no partial state is kept.
- Slave strobes are gated by ack, never by req alone.

Optional Feature:
- Macro ARB_CPU_PRIORITY_EN.
- Defined:
  - Tie in IDLE always goes to master 0.
  - Master 0 preempts master 1 after master 1's current access: OWN1 -> OWN0 when m0_req, regardless of burst_cnt.
  - MAX_BURST applies only to master 0.
- Undefined: round robin with MAX_BURST fairness, as above.

Decomposition:
- Shared package bus_pkg:
  - state encoding localparams (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2).
  - SEL_BIT default.
  - Address-map constants: DMEM base 0x00000000, PERIPH base 0x40000000.
- Sub-module bus_slave_mux: the combinational owner/address-decode routing of strobes, addr, wdata and rdata. The arbiter FSM and burst counter stay in the top module.

Test Plan:
- Reset then m0_req=1, m0_wr=1, addr=0x00000010, wdata=0xDEADBEEF:
  - cycle 1: m0_ack=0, cpu_stall=1;
  - cycle 2: mem_wr=1, mem_addr=0x10, m0_ack=1, per_wr=0.
- OWN0 hold m0_req with m0_rd, addr=0x40000014, per_rdata=0x000000A5 -> per_rd=1, m0_rdata=0xA5, mem_rd=0, ack every cycle with no bubble.
- Both req from IDLE after reset -> OWN0 first. m0 drops -> next cycle OWN1 with m1_ack=1. Both idle, then both req -> OWN0 (round robin).
- MAX_BURST=8, m1 owns and req held, m0_req held:
  - m1 gets exactly 8 acks, then owner=OWN0 the next cycle;
  - cpu_stall=1 for those 8 cycles.
- Assert reset low mid-write in OWN1 -> all strobes and acks 0 the same cycle; after release, state IDLE and the first tie goes to m0.
- With ARB_CPU_PRIORITY_EN, m1 bursting and m0_req rising -> one more m1 ack, then OWN0. Without it, m1 continues to MAX_BURST.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the data-side bus arbiter: FSM state encoding,
// address-map constants and burst counter helpers.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int unsigned SEL_BIT_DEF = 30;
    localparam int unsigned BURST_W     = 8;

    localparam logic [31:0] DMEM_BASE   = 32'h0000_0000;
    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

    // Saturating increment for the per-owner burst counter.
    function automatic logic [BURST_W-1:0] burst_inc(
        input logic [BURST_W-1:0] cnt,
        input logic [BURST_W-1:0] max
    );
        return (cnt >= max) ? max : BURST_W'(cnt + 1'b1);
    endfunction

endpackage

// File: rtl/bus_slave_mux.sv
// Combinational routing of the owning master onto DataMemory or Peripheral,
// selected by one address bit; strobes and read data are gated by the ack.
module bus_slave_mux
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SEL_BIT = SEL_BIT_DEF
) (
    input  logic [1:0]        state,
    input  logic              m0_req,
    input  logic              m0_rd,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_rd,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              per_rd,
    output logic              per_wr,
    output logic [ADDR_W-1:0] per_addr,
    output logic [DATA_W-1:0] per_wdata,
    input  logic [DATA_W-1:0] per_rdata
);

    logic              sel_ack;
    logic              sel_rd;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] sel_rdata;
    logic              to_per;

    // Pick the owning master's request; nothing is forwarded in IDLE.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (state)
            OWN0: begin
                sel_ack   = m0_req;
                sel_rd    = m0_rd;
                sel_wr    = m0_wr;
                sel_addr  = m0_addr;
                sel_wdata = m0_wdata;
            end
            OWN1: begin
                sel_ack   = m1_req;
                sel_rd    = m1_rd;
                sel_wr    = m1_wr;
                sel_addr  = m1_addr;
                sel_wdata = m1_wdata;
            end
            default: begin
                sel_ack = 1'b0;
            end
        endcase
    end

    assign to_per    = sel_addr[SEL_BIT];
    assign sel_rdata = to_per ? per_rdata : mem_rdata;

    assign m0_ack   = (state == OWN0) && m0_req;
    assign m1_ack   = (state == OWN1) && m1_req;
    assign m0_rdata = m0_ack ? sel_rdata : '0;
    assign m1_rdata = m1_ack ? sel_rdata : '0;

    // Both rd and wr are forwarded when set together; the slave gives the write priority.
    assign mem_rd    = sel_ack && sel_rd && !to_per;
    assign mem_wr    = sel_ack && sel_wr && !to_per;
    assign per_rd    = sel_ack && sel_rd && to_per;
    assign per_wr    = sel_ack && sel_wr && to_per;
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;
    assign per_addr  = sel_addr;
    assign per_wdata = sel_wdata;

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter (CPU = master 0, DMA = master 1) with burst fairness.
// Define ARB_CPU_PRIORITY_EN to let the CPU win ties and preempt DMA bursts.
module data_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned SEL_BIT   = SEL_BIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_rd,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              cpu_stall,
    input  logic              m1_req,
    input  logic              m1_rd,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              per_rd,
    output logic              per_wr,
    output logic [ADDR_W-1:0] per_addr,
    output logic [DATA_W-1:0] per_wdata,
    input  logic [DATA_W-1:0] per_rdata,
    output logic [1:0]        owner
);

    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    arb_state_t         state;
    arb_state_t         state_nx;
    logic               last_gnt;
    logic               last_gnt_nx;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_cnt_nx;
    logic               burst_done;
    logic               acked;

    // The counter saturates at MAX_BURST, so the hand-over test uses >= to stay live.
    assign burst_done = burst_cnt >= BURST_LAST;
    assign acked      = m0_ack || m1_ack;

    always_comb begin
        state_nx     = state;
        last_gnt_nx  = last_gnt;
        burst_cnt_nx = burst_cnt;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
`ifdef ARB_CPU_PRIORITY_EN
                    state_nx = OWN0;
`else
                    state_nx = last_gnt ? OWN0 : OWN1;
`endif
                end else if (m0_req) begin
                    state_nx = OWN0;
                end else if (m1_req) begin
                    state_nx = OWN1;
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    state_nx = m1_req ? OWN1 : IDLE;
                end else if (m1_req && burst_done) begin
                    state_nx = OWN1;
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    state_nx = m0_req ? OWN0 : IDLE;
`ifdef ARB_CPU_PRIORITY_EN
                end else if (m0_req) begin
`else
                end else if (m0_req && burst_done) begin
`endif
                    state_nx = OWN0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A new owner starts a fresh burst; IDLE keeps the last grant for round robin.
        if (state_nx != state) begin
            burst_cnt_nx = '0;
            if (state_nx != IDLE) begin
                last_gnt_nx = (state_nx == OWN1);
            end
        end else if (acked) begin
            burst_cnt_nx = burst_inc(burst_cnt, BURST_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            last_gnt  <= last_gnt_nx;
            burst_cnt <= burst_cnt_nx;
        end
    end

    assign owner     = {state == OWN1, state == OWN0};
    assign cpu_stall = m0_req && !m0_ack;

    bus_slave_mux #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SEL_BIT (SEL_BIT)
    ) u_mux (
        .state     (state),
        .m0_req    (m0_req),
        .m0_rd     (m0_rd),
        .m0_wr     (m0_wr),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_rd     (m1_rd),
        .m1_wr     (m1_wr),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .per_rd    (per_rd),
        .per_wr    (per_wr),
        .per_addr  (per_addr),
        .per_wdata (per_wdata),
        .per_rdata (per_rdata)
    );

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter; expectations follow ARB_CPU_PRIORITY_EN when defined.
module tb_data_bus_arbiter;

    localparam int unsigned MB = 8;
    localparam logic [31:0] Z      = 32'h0;
    localparam logic [31:0] MEM_RD = 32'h1234_5678;
    localparam logic [31:0] PER_RD = 32'h0000_00A5;
`ifdef ARB_CPU_PRIORITY_EN
    localparam int unsigned M1_BURST = 1;
    localparam int unsigned M1_TAIL  = 1;
`else
    localparam int unsigned M1_BURST = MB;
    localparam int unsigned M1_TAIL  = MB - 3;
`endif

    logic        clk;
    logic        reset;
    logic        m0_req, m0_rd, m0_wr, m0_ack, cpu_stall;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_rd, m1_wr, m1_ack;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_rd, mem_wr, per_rd, per_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] per_addr, per_wdata, per_rdata;
    logic [1:0]  owner;

    typedef struct {
        logic        rst;
        logic        r0, rd0, wr0;
        logic [31:0] a0, d0;
        logic        r1, rd1, wr1;
        logic [31:0] a1, d1;
    } stim_t;

    typedef struct {
        string       tag;
        logic [8:0]  flags;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [63:0] bus;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB), .SEL_BIT(30)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .cpu_stall(cpu_stall),
        .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .per_rd(per_rd), .per_wr(per_wr), .per_addr(per_addr), .per_wdata(per_wdata), .per_rdata(per_rdata),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input logic rst, input logic r0, input logic rd0, input logic wr0,
                                 input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic rd1, input logic wr1,
                                 input logic [31:0] a1, input logic [31:0] d1);
        stim_t s;
        s.rst = rst; s.r0 = r0; s.rd0 = rd0; s.wr0 = wr0; s.a0 = a0; s.d0 = d0;
        s.r1 = r1; s.rd1 = rd1; s.wr1 = wr1; s.a1 = a1; s.d1 = d1;
        return s;
    endfunction

    // flags = {m0_ack, m1_ack, mem_rd, mem_wr, per_rd, per_wr, owner[1:0], cpu_stall}
    function automatic logic [8:0] flg(input logic a0, input logic a1, input logic mr, input logic mw,
                                       input logic pr, input logic pw, input logic [1:0] ow, input logic sl);
        return {a0, a1, mr, mw, pr, pw, ow, sl};
    endfunction

    function automatic exp_t ex(input string tag, input logic [8:0] f, input logic [31:0] r0,
                                input logic [31:0] r1, input logic [63:0] bus);
        exp_t e;
        e.tag = tag; e.flags = f; e.r0 = r0; e.r1 = r1; e.bus = bus;
        return e;
    endfunction

    function automatic logic [8:0] now_flags();
        return {m0_ack, m1_ack, mem_rd, mem_wr, per_rd, per_wr, owner, cpu_stall};
    endfunction

    task automatic drive(input stim_t s);
        reset = s.rst;
        m0_req = s.r0; m0_rd = s.rd0; m0_wr = s.wr0; m0_addr = s.a0; m0_wdata = s.d0;
        m1_req = s.r1; m1_rd = s.rd1; m1_wr = s.wr1; m1_addr = s.a1; m1_wdata = s.d1;
    endtask

    task automatic test_reset();
        stim_t q[$];
        exp_t  e;
        q.push_back(st(0, 0,0,0,Z,Z, 0,0,0,Z,Z));
        sb.push_back(ex("rst_idle", flg(0,0,0,0,0,0,2'b00,0), Z, Z, 64'h0));
        q.push_back(st(0, 1,0,1,32'h10,32'hDEAD_BEEF, 1,0,1,32'h4000_0000,32'h1));
        sb.push_back(ex("rst_req", flg(0,0,0,0,0,0,2'b00,1), Z, Z, 64'h0));
        while (q.size() > 0) begin
            drive(q.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (now_flags() !== e.flags) begin errors++; $display("FAIL %s flags got %b exp %b", e.tag, now_flags(), e.flags); end
            checks++;
            if ({m0_rdata, m1_rdata} !== {e.r0, e.r1}) begin errors++; $display("FAIL %s rdata got %h/%h exp %h/%h", e.tag, m0_rdata, m1_rdata, e.r0, e.r1); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cpu_access();
        stim_t q[$];
        exp_t  e;
        q.push_back(st(1, 1,0,1,32'h10,32'hDEAD_BEEF, 0,0,0,Z,Z));
        sb.push_back(ex("wr_arb", flg(0,0,0,0,0,0,2'b00,1), Z, Z, 64'h0));
        q.push_back(st(1, 1,0,1,32'h10,32'hDEAD_BEEF, 0,0,0,Z,Z));
        sb.push_back(ex("wr_own0", flg(1,0,0,1,0,0,2'b01,0), MEM_RD, Z, {32'h10, 32'hDEAD_BEEF}));
        for (int i = 0; i < 4; i++) begin
            q.push_back(st(1, 1,1,0,32'h4000_0014,Z, 0,0,0,Z,Z));
            sb.push_back(ex("rd_per", flg(1,0,0,0,1,0,2'b01,0), PER_RD, Z, {32'h4000_0014, Z}));
        end
        q.push_back(st(1, 1,1,1,32'h4000_0008,32'h0BAD_F00D, 0,0,0,Z,Z));
        sb.push_back(ex("rd_wr_both", flg(1,0,0,0,1,1,2'b01,0), PER_RD, Z, {32'h4000_0008, 32'h0BAD_F00D}));
        q.push_back(st(1, 0,0,0,Z,Z, 0,0,0,Z,Z));
        sb.push_back(ex("release0", flg(0,0,0,0,0,0,2'b01,0), Z, Z, 64'h0));
        q.push_back(st(1, 0,0,0,Z,Z, 0,0,0,Z,Z));
        sb.push_back(ex("idle_again", flg(0,0,0,0,0,0,2'b00,0), Z, Z, 64'h0));
        while (q.size() > 0) begin
            drive(q.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (now_flags() !== e.flags) begin errors++; $display("FAIL %s flags got %b exp %b", e.tag, now_flags(), e.flags); end
            checks++;
            if ({m0_rdata, m1_rdata} !== {e.r0, e.r1}) begin errors++; $display("FAIL %s rdata got %h/%h exp %h/%h", e.tag, m0_rdata, m1_rdata, e.r0, e.r1); end
            if (e.flags[6] | e.flags[5]) begin
                checks++;
                if ({mem_addr, mem_wdata} !== e.bus) begin errors++; $display("FAIL %s mem bus got %h exp %h", e.tag, {mem_addr, mem_wdata}, e.bus); end
            end
            if (e.flags[4] | e.flags[3]) begin
                checks++;
                if ({per_addr, per_wdata} !== e.bus) begin errors++; $display("FAIL %s per bus got %h exp %h", e.tag, {per_addr, per_wdata}, e.bus); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_round_robin();
        stim_t q[$];
        stim_t both, only1, none;
        exp_t  e;
        both  = st(1, 1,1,0,32'h20,Z, 1,0,1,32'h4000_0030,32'hCAFE_0001);
        only1 = st(1, 0,0,0,Z,Z,      1,0,1,32'h4000_0030,32'hCAFE_0001);
        none  = st(1, 0,0,0,Z,Z,      0,0,0,Z,Z);
        q.push_back(st(0, 0,0,0,Z,Z, 0,0,0,Z,Z));
        sb.push_back(ex("rr_rst", flg(0,0,0,0,0,0,2'b00,0), Z, Z, 64'h0));
        q.push_back(both);  sb.push_back(ex("rr_tie1", flg(0,0,0,0,0,0,2'b00,1), Z, Z, 64'h0));
        q.push_back(both);  sb.push_back(ex("rr_own0", flg(1,0,1,0,0,0,2'b01,0), MEM_RD, Z, {32'h20, Z}));
        q.push_back(only1); sb.push_back(ex("rr_drop0", flg(0,0,0,0,0,0,2'b01,0), Z, Z, 64'h0));
        q.push_back(only1); sb.push_back(ex("rr_own1", flg(0,1,0,0,0,1,2'b10,0), Z, PER_RD, {32'h4000_0030, 32'hCAFE_0001}));
        q.push_back(none);  sb.push_back(ex("rr_drop1", flg(0,0,0,0,0,0,2'b10,0), Z, Z, 64'h0));
        q.push_back(both);  sb.push_back(ex("rr_tie2", flg(0,0,0,0,0,0,2'b00,1), Z, Z, 64'h0));
        q.push_back(both);  sb.push_back(ex("rr_own0b", flg(1,0,1,0,0,0,2'b01,0), MEM_RD, Z, {32'h20, Z}));
        q.push_back(none);  sb.push_back(ex("rr_drop0b", flg(0,0,0,0,0,0,2'b01,0), Z, Z, 64'h0));
        q.push_back(both);  sb.push_back(ex("rr_tie3", flg(0,0,0,0,0,0,2'b00,1), Z, Z, 64'h0));
        q.push_back(both);
`ifdef ARB_CPU_PRIORITY_EN
        sb.push_back(ex("rr_tie3_win", flg(1,0,1,0,0,0,2'b01,0), MEM_RD, Z, {32'h20, Z}));
`else
        sb.push_back(ex("rr_tie3_win", flg(0,1,0,0,0,1,2'b10,1), Z, PER_RD, {32'h4000_0030, 32'hCAFE_0001}));
`endif
        while (q.size() > 0) begin
            drive(q.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (now_flags() !== e.flags) begin errors++; $display("FAIL %s flags got %b exp %b", e.tag, now_flags(), e.flags); end
            checks++;
            if ({m0_rdata, m1_rdata} !== {e.r0, e.r1}) begin errors++; $display("FAIL %s rdata got %h/%h exp %h/%h", e.tag, m0_rdata, m1_rdata, e.r0, e.r1); end
            if (e.flags[6] | e.flags[5]) begin
                checks++;
                if ({mem_addr, mem_wdata} !== e.bus) begin errors++; $display("FAIL %s mem bus got %h exp %h", e.tag, {mem_addr, mem_wdata}, e.bus); end
            end
            if (e.flags[4] | e.flags[3]) begin
                checks++;
                if ({per_addr, per_wdata} !== e.bus) begin errors++; $display("FAIL %s per bus got %h exp %h", e.tag, {per_addr, per_wdata}, e.bus); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_max_burst();
        stim_t       q[$];
        exp_t        e;
        logic [31:0] a, d;
        q.push_back(st(0, 0,0,0,Z,Z, 0,0,0,Z,Z));
        sb.push_back(ex("mb_rst", flg(0,0,0,0,0,0,2'b00,0), Z, Z, 64'h0));
        q.push_back(st(1, 0,0,0,Z,Z, 1,0,1,32'h100,Z));
        sb.push_back(ex("mb_arb", flg(0,0,0,0,0,0,2'b00,0), Z, Z, 64'h0));
        for (int i = 0; i < int'(M1_BURST); i++) begin
            a = 32'h100 + 32'(4 * i);
            d = 32'hB000_0000 + 32'(i);
            q.push_back(st(1, 1,1,0,32'h8,Z, 1,0,1,a,d));
            sb.push_back(ex("mb_m1", flg(0,1,0,1,0,0,2'b10,1), Z, MEM_RD, {a, d}));
        end
        for (int j = 0; j < int'(MB); j++) begin
            q.push_back(st(1, 1,1,0,32'h8,Z, 1,0,1,32'h200,32'hC0DE));
            sb.push_back(ex("mb_m0", flg(1,0,1,0,0,0,2'b01,0), MEM_RD, Z, {32'h8, Z}));
        end
        q.push_back(st(1, 1,1,0,32'h8,Z, 1,0,1,32'h200,32'hC0DE));
        sb.push_back(ex("mb_back1", flg(0,1,0,1,0,0,2'b10,1), Z, MEM_RD, {32'h200, 32'hC0DE}));
        while (q.size() > 0) begin
            drive(q.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (now_flags() !== e.flags) begin errors++; $display("FAIL %s flags got %b exp %b", e.tag, now_flags(), e.flags); end
            checks++;
            if ({m0_rdata, m1_rdata} !== {e.r0, e.r1}) begin errors++; $display("FAIL %s rdata got %h/%h exp %h/%h", e.tag, m0_rdata, m1_rdata, e.r0, e.r1); end
            if (e.flags[6] | e.flags[5]) begin
                checks++;
                if ({mem_addr, mem_wdata} !== e.bus) begin errors++; $display("FAIL %s mem bus got %h exp %h", e.tag, {mem_addr, mem_wdata}, e.bus); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_preempt();
        stim_t q[$];
        exp_t  e;
        q.push_back(st(0, 0,0,0,Z,Z, 0,0,0,Z,Z));
        sb.push_back(ex("pe_rst", flg(0,0,0,0,0,0,2'b00,0), Z, Z, 64'h0));
        q.push_back(st(1, 0,0,0,Z,Z, 1,0,1,32'h300,32'h1));
        sb.push_back(ex("pe_arb", flg(0,0,0,0,0,0,2'b00,0), Z, Z, 64'h0));
        for (int i = 0; i < 3; i++) begin
            q.push_back(st(1, 0,0,0,Z,Z, 1,0,1,32'h300,32'h1));
            sb.push_back(ex("pe_m1_alone", flg(0,1,0,1,0,0,2'b10,0), Z, MEM_RD, {32'h300, 32'h1}));
        end
        for (int i = 0; i < int'(M1_TAIL); i++) begin
            q.push_back(st(1, 1,1,0,32'h4000_0004,Z, 1,0,1,32'h300,32'h1));
            sb.push_back(ex("pe_m1_tail", flg(0,1,0,1,0,0,2'b10,1), Z, MEM_RD, {32'h300, 32'h1}));
        end
        q.push_back(st(1, 1,1,0,32'h4000_0004,Z, 1,0,1,32'h300,32'h1));
        sb.push_back(ex("pe_own0", flg(1,0,0,0,1,0,2'b01,0), PER_RD, Z, {32'h4000_0004, Z}));
        while (q.size() > 0) begin
            drive(q.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (now_flags() !== e.flags) begin errors++; $display("FAIL %s flags got %b exp %b", e.tag, now_flags(), e.flags); end
            checks++;
            if ({m0_rdata, m1_rdata} !== {e.r0, e.r1}) begin errors++; $display("FAIL %s rdata got %h/%h exp %h/%h", e.tag, m0_rdata, m1_rdata, e.r0, e.r1); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        stim_t q[$];
        exp_t  e;
        q.push_back(st(0, 0,0,0,Z,Z, 0,0,0,Z,Z));
        sb.push_back(ex("rm_rst", flg(0,0,0,0,0,0,2'b00,0), Z, Z, 64'h0));
        q.push_back(st(1, 0,0,0,Z,Z, 1,0,1,32'h4000_0040,32'h55AA));
        sb.push_back(ex("rm_arb", flg(0,0,0,0,0,0,2'b00,0), Z, Z, 64'h0));
        q.push_back(st(1, 0,0,0,Z,Z, 1,0,1,32'h4000_0040,32'h55AA));
        sb.push_back(ex("rm_own1", flg(0,1,0,0,0,1,2'b10,0), Z, PER_RD, {32'h4000_0040, 32'h55AA}));
        q.push_back(st(0, 1,1,0,32'h20,Z, 1,0,1,32'h4000_0040,32'h55AA));
        sb.push_back(ex("rm_abort", flg(0,0,0,0,0,0,2'b00,1), Z, Z, 64'h0));
        q.push_back(st(1, 1,1,0,32'h20,Z, 1,0,1,32'h4000_0040,32'h55AA));
        sb.push_back(ex("rm_idle", flg(0,0,0,0,0,0,2'b00,1), Z, Z, 64'h0));
        q.push_back(st(1, 1,1,0,32'h20,Z, 1,0,1,32'h4000_0040,32'h55AA));
        sb.push_back(ex("rm_tie_m0", flg(1,0,1,0,0,0,2'b01,0), MEM_RD, Z, {32'h20, Z}));
        while (q.size() > 0) begin
            drive(q.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (now_flags() !== e.flags) begin errors++; $display("FAIL %s flags got %b exp %b", e.tag, now_flags(), e.flags); end
            checks++;
            if ({m0_rdata, m1_rdata} !== {e.r0, e.r1}) begin errors++; $display("FAIL %s rdata got %h/%h exp %h/%h", e.tag, m0_rdata, m1_rdata, e.r0, e.r1); end
            if (e.flags[4] | e.flags[3]) begin
                checks++;
                if ({per_addr, per_wdata} !== e.bus) begin errors++; $display("FAIL %s per bus got %h exp %h", e.tag, {per_addr, per_wdata}, e.bus); end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        mem_rdata = MEM_RD;
        per_rdata = PER_RD;
        test_reset();
        test_cpu_access();
        test_round_robin();
        test_max_burst();
        test_preempt();
        test_reset_mid();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d entries exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
